// File: rtl/config_bus_master_pkg.sv
// rtl/config_bus_master_pkg.sv - shared types and sizing helpers for the config bus master.
// Optional verify-after-write feature: CONFIG_BUS_MASTER_VERIFY_EN.
package config_bus_master_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP,
    ST_VERIFY
  } state_t;

  // Latency down-counter never collapses to zero width, even for READ_LATENCY=0.
  function automatic int lat_cnt_width(input int read_latency);
    return (read_latency < 1) ? 1 : $clog2(read_latency + 1);
  endfunction

endpackage

// File: rtl/config_bus_master_if.sv
// rtl/config_bus_master_if.sv - command/response channels and core-side config pins.
// Carries verify_err/verify_err_count only when CONFIG_BUS_MASTER_VERIFY_EN is defined.
interface config_bus_master_if
  import config_bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] config_config_addr;
  logic [DATA_WIDTH-1:0] config_config_data;
  logic                  config_read;
  logic                  config_write;
  logic [DATA_WIDTH-1:0] read_config_data;
`ifdef CONFIG_BUS_MASTER_VERIFY_EN
  logic                  verify_err;
  logic [15:0]           verify_err_count;
`endif

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready, read_config_data,
`ifdef CONFIG_BUS_MASTER_VERIFY_EN
    output verify_err, verify_err_count,
`endif
    output cmd_ready, rsp_valid, rsp_data, busy,
    output config_config_addr, config_config_data, config_read, config_write
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready, read_config_data,
`ifdef CONFIG_BUS_MASTER_VERIFY_EN
    input  verify_err, verify_err_count,
`endif
    input  cmd_ready, rsp_valid, rsp_data, busy,
    input  config_config_addr, config_config_data, config_read, config_write
  );

endinterface

// File: rtl/config_bus_master.sv
// rtl/config_bus_master.sv - one-at-a-time read/write initiator on the per-core config bus.
// CONFIG_BUS_MASTER_VERIFY_EN adds a read-back check after every write.
module config_bus_master
  import config_bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int READ_LATENCY = 0
) (
  input  logic                clk,
  input  logic                reset,
  config_bus_master_if.master bus
);

  localparam int            CW       = lat_cnt_width(READ_LATENCY);
  localparam logic [CW-1:0] LAT_LOAD = CW'(READ_LATENCY);

  state_t                state;
  state_t                next_state;
  logic [CW-1:0]         lat_cnt;
  logic                  cmd_ready_q;
  logic                  busy_q;
  logic                  cfg_read_q;
  logic                  cfg_write_q;
  logic                  rsp_valid_q;
  logic [ADDR_WIDTH-1:0] cfg_addr_q;
  logic [DATA_WIDTH-1:0] cfg_data_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  accept;
  logic                  last_read;

  // cmd_ready_q is still 0 in the first IDLE cycle after reset release.
  assign accept    = (state == ST_IDLE) && cmd_ready_q && bus.cmd_valid;
  assign last_read = (lat_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = bus.cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
`ifdef CONFIG_BUS_MASTER_VERIFY_EN
        next_state = ST_VERIFY;
`else
        next_state = ST_IDLE;
`endif
      end
      ST_READ: begin
        if (last_read) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
`ifdef CONFIG_BUS_MASTER_VERIFY_EN
      ST_VERIFY: begin
        if (last_read) begin
          next_state = ST_IDLE;
        end
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // Reload while idle/writing so the read phase always starts from READ_LATENCY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= '0;
    end else if (state == ST_IDLE || state == ST_WRITE) begin
      lat_cnt <= LAT_LOAD;
    end else if (!last_read) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Outputs are registered from next_state so each one is valid for the whole state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_read_q  <= 1'b0;
      cfg_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      cmd_ready_q <= (next_state == ST_IDLE);
      busy_q      <= (next_state != ST_IDLE);
      cfg_write_q <= (next_state == ST_WRITE);
      cfg_read_q  <= (next_state == ST_READ) || (next_state == ST_VERIFY);
      rsp_valid_q <= (next_state == ST_RESP);
      if (accept) begin
        cfg_addr_q <= bus.cmd_addr;
        if (bus.cmd_write) begin
          cfg_data_q <= bus.cmd_data;
        end
      end
      if (state == ST_READ && last_read) begin
        rsp_data_q <= bus.read_config_data;
      end
    end
  end

`ifdef CONFIG_BUS_MASTER_VERIFY_EN
  logic        verify_err_q;
  logic [15:0] verify_err_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      verify_err_q       <= 1'b0;
      verify_err_count_q <= '0;
    end else begin
      verify_err_q <= 1'b0;
      if (state == ST_VERIFY && last_read && (bus.read_config_data != cfg_data_q)) begin
        verify_err_q <= 1'b1;
        if (verify_err_count_q != 16'hFFFF) begin
          verify_err_count_q <= verify_err_count_q + 16'd1;
        end
      end
    end
  end

  assign bus.verify_err       = verify_err_q;
  assign bus.verify_err_count = verify_err_count_q;
`endif

  assign bus.cmd_ready          = cmd_ready_q;
  assign bus.busy               = busy_q;
  assign bus.config_read        = cfg_read_q;
  assign bus.config_write       = cfg_write_q;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_data           = rsp_data_q;
  assign bus.config_config_addr = cfg_addr_q;
  assign bus.config_config_data = cfg_data_q;

endmodule

// File: tb/tb_config_bus_master.sv
// tb/tb_config_bus_master.sv - directed self-checking bench for config_bus_master.
// Three instances cover READ_LATENCY 0, 3 and 2; CONFIG_BUS_MASTER_VERIFY_EN adds the verify steps.
module tb_config_bus_master;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_c;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  config_bus_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_a ();
  config_bus_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_b ();
  config_bus_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_c ();

  config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(0)) dut_a (
    .clk(clk), .reset(rst_n), .bus(bus_a));
  config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(rst_n), .bus(bus_b));
  config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(2)) dut_c (
    .clk(clk), .reset(rst_c), .bus(bus_c));

  // Core A: register file with combinational readback, optional bit-0 corruption on addr 01.
  logic [31:0] mem_a [256];
  logic        corrupt;
  always_ff @(posedge clk) begin
    if (bus_a.config_write) begin
      mem_a[bus_a.config_config_addr] <= bus_a.config_config_data ^
        {31'b0, corrupt && (bus_a.config_config_addr == 8'h01)};
    end
  end
  assign bus_a.read_config_data = mem_a[bus_a.config_config_addr];

  // Core B: data valid only from the 4th cycle of config_read onwards.
  logic [31:0] mem_b [256];
  logic [3:0]  rcnt_b;
  always_ff @(posedge clk) begin
    if (bus_b.config_write) begin
      mem_b[bus_b.config_config_addr] <= bus_b.config_config_data;
    end
    rcnt_b <= bus_b.config_read ? 4'(rcnt_b + 4'd1) : 4'd0;
  end
  assign bus_b.read_config_data = (bus_b.config_read && rcnt_b >= 4'd3) ?
                                  mem_b[bus_b.config_config_addr] : 32'hBAD0BAD0;

  assign bus_c.read_config_data = {24'h55AA55, bus_c.config_config_addr};

  logic        b2b_write [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0]  b2b_addr  [6] = '{8'h03, 8'h03, 8'h04, 8'h04, 8'h03, 8'h03};
  logic [31:0] b2b_data  [6] = '{32'hA1A1A1A1, 32'h0, 32'hB2B2B2B2, 32'h0, 32'hC3C3C3C3, 32'h0};
  logic [31:0] b2b_exp   [3] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int which);
    int n = 0;
    while (((which == 0) ? bus_a.cmd_ready : bus_b.cmd_ready) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, (which == 0) ? bus_a.cmd_ready : bus_b.cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx, nrsp, cyc, hi, n, pulses;
    logic accepted, seen;

    rst_n = 1'b0; rst_c = 1'b0; corrupt = 1'b0;
    bus_a.cmd_valid = 0; bus_a.cmd_write = 0; bus_a.cmd_addr = 0; bus_a.cmd_data = 0; bus_a.rsp_ready = 0;
    bus_b.cmd_valid = 0; bus_b.cmd_write = 0; bus_b.cmd_addr = 0; bus_b.cmd_data = 0; bus_b.rsp_ready = 0;
    bus_c.cmd_valid = 0; bus_c.cmd_write = 0; bus_c.cmd_addr = 0; bus_c.cmd_data = 0; bus_c.rsp_ready = 0;
    tick(); tick();

    check("rst_cmd_ready", bus_a.cmd_ready, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_strobes", {bus_a.config_read, bus_a.config_write, bus_a.rsp_valid}, 0);
    check("rst_addr", bus_a.config_config_addr, 0);
    check("rst_data", bus_a.config_config_data, 0);
    check("rst_rsp_data", bus_a.rsp_data, 0);
    #2 rst_n = 1'b1; rst_c = 1'b1;
    tick();
    check("post_rst_ready_a", bus_a.cmd_ready, 1);
    check("post_rst_ready_b", bus_b.cmd_ready, 1);
    check("post_rst_ready_c", bus_c.cmd_ready, 1);

    // Single write then read-back at latency 0.
    bus_a.cmd_valid = 1; bus_a.cmd_write = 1; bus_a.cmd_addr = 8'h01; bus_a.cmd_data = 32'hDEADBEEF;
    tick();
    bus_a.cmd_valid = 0;
    check("wr_strobe", bus_a.config_write, 1);
    check("wr_no_read", bus_a.config_read, 0);
    check("wr_addr", bus_a.config_config_addr, 8'h01);
    check("wr_data", bus_a.config_config_data, 32'hDEADBEEF);
    check("wr_cmd_ready", bus_a.cmd_ready, 0);
    check("wr_busy", bus_a.busy, 1);
    tick();
    check("wr_strobe_drop", bus_a.config_write, 0);
`ifndef CONFIG_BUS_MASTER_VERIFY_EN
    check("wr_ready_next", bus_a.cmd_ready, 1);
`else
    wait_ready("wr_ready_after_verify", 0);
`endif
    bus_a.cmd_valid = 1; bus_a.cmd_write = 0; bus_a.cmd_addr = 8'h01; bus_a.cmd_data = 32'h11111111;
    tick();
    bus_a.cmd_valid = 0;
    check("rd_strobe", bus_a.config_read, 1);
    check("rd_no_write", bus_a.config_write, 0);
    check("rd_data_kept", bus_a.config_config_data, 32'hDEADBEEF);
    tick();
    check("rd_rsp_valid", bus_a.rsp_valid, 1);
    check("rd_rsp_data", bus_a.rsp_data, 32'hDEADBEEF);
    check("rd_strobe_drop", bus_a.config_read, 0);
    bus_a.rsp_ready = 1;
    tick();
    bus_a.rsp_ready = 0;
    check("rd_rsp_done", bus_a.rsp_valid, 0);
    check("rd_ready_again", bus_a.cmd_ready, 1);

    // Response back-pressure with a write pending behind it.
    bus_a.cmd_valid = 1; bus_a.cmd_write = 0; bus_a.cmd_addr = 8'h01;
    tick();
    bus_a.cmd_write = 1; bus_a.cmd_addr = 8'h02; bus_a.cmd_data = 32'hCAFEF00D;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", bus_a.rsp_valid, 1);
      check("bp_rsp_data", bus_a.rsp_data, 32'hDEADBEEF);
      check("bp_cmd_ready", bus_a.cmd_ready, 0);
      check("bp_no_write", bus_a.config_write, 0);
      tick();
    end
    bus_a.rsp_ready = 1;
    tick();
    bus_a.rsp_ready = 0;
    check("bp_release_rsp", bus_a.rsp_valid, 0);
    check("bp_release_ready", bus_a.cmd_ready, 1);
    tick();
    bus_a.cmd_valid = 0;
    check("bp_write", bus_a.config_write, 1);
    check("bp_write_addr", bus_a.config_config_addr, 8'h02);
    check("bp_write_data", bus_a.config_config_data, 32'hCAFEF00D);
    wait_ready("bp_ready_after_write", 0);

    // Back-to-back alternating write/read commands.
    idx = 0; nrsp = 0; cyc = 0;
    bus_a.rsp_ready = 1;
    while ((idx < 6 || nrsp < 3) && cyc < 100) begin
      bus_a.cmd_valid = (idx < 6);
      if (idx < 6) begin
        bus_a.cmd_write = b2b_write[idx];
        bus_a.cmd_addr  = b2b_addr[idx];
        bus_a.cmd_data  = b2b_data[idx];
      end
      #1;
      accepted = bus_a.cmd_ready && bus_a.cmd_valid;
      if (bus_a.rsp_valid && nrsp < 3) begin
        check("b2b_rsp_data", bus_a.rsp_data, b2b_exp[nrsp]);
        nrsp++;
      end
      tick();
      if (accepted) idx++;
      check("b2b_no_overlap", bus_a.config_read & bus_a.config_write, 0);
      check("b2b_busy", bus_a.busy, bus_a.config_read | bus_a.config_write | bus_a.rsp_valid);
      check("b2b_ready", bus_a.cmd_ready, !bus_a.busy);
      cyc++;
    end
    bus_a.cmd_valid = 0; bus_a.rsp_ready = 0;
    check("b2b_all_rsp", nrsp, 3);
    check("b2b_all_cmd", idx, 6);
    tick();

    // Latency 3: config_read held 4 cycles, data captured on the last one.
    bus_b.cmd_valid = 1; bus_b.cmd_write = 1; bus_b.cmd_addr = 8'h00; bus_b.cmd_data = 32'h12345678;
    tick();
    bus_b.cmd_valid = 0;
    wait_ready("lat3_ready_after_write", 1);
    bus_b.cmd_valid = 1; bus_b.cmd_write = 0; bus_b.cmd_addr = 8'h00;
    tick();
    bus_b.cmd_valid = 0;
    hi = 0; n = 0;
    while (bus_b.rsp_valid !== 1'b1 && n < 12) begin
      if (bus_b.config_read) hi++;
      tick();
      n++;
    end
    check("lat3_read_cycles", hi, 4);
    check("lat3_rsp_valid", bus_b.rsp_valid, 1);
    check("lat3_rsp_data", bus_b.rsp_data, 32'h12345678);
    bus_b.rsp_ready = 1;
    tick();
    bus_b.rsp_ready = 0;
    check("lat3_rsp_done", bus_b.rsp_valid, 0);

    // Reset mid-read at latency 2.
    bus_c.cmd_valid = 1; bus_c.cmd_write = 0; bus_c.cmd_addr = 8'h05;
    tick();
    bus_c.cmd_valid = 0;
    check("c_read_1", bus_c.config_read, 1);
    tick();
    check("c_read_2", bus_c.config_read, 1);
    rst_c = 1'b0;
    #1;
    check("rst_mid_read", bus_c.config_read, 0);
    check("rst_mid_rsp", bus_c.rsp_valid, 0);
    check("rst_mid_busy", bus_c.busy, 0);
    tick(); tick();
    rst_c = 1'b1;
    tick();
    check("c_ready_after_rst", bus_c.cmd_ready, 1);
    bus_c.rsp_ready = 1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | bus_c.rsp_valid;
      tick();
    end
    check("c_no_stale_rsp", seen, 0);
    bus_c.cmd_valid = 1; bus_c.cmd_addr = 8'h06;
    tick();
    bus_c.cmd_valid = 0;
    check("c_accept", bus_c.config_read, 1);
    check("c_accept_addr", bus_c.config_config_addr, 8'h06);
    n = 0;
    while (bus_c.rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("c_rsp_valid", bus_c.rsp_valid, 1);
    check("c_rsp_data", bus_c.rsp_data, 32'h55AA5506);
    tick();
    bus_c.rsp_ready = 0;
    check("c_rsp_done", bus_c.rsp_valid, 0);

`ifdef CONFIG_BUS_MASTER_VERIFY_EN
    // Verify-after-write: corrupted core on addr 01, clean on addr 00.
    corrupt = 1'b1;
    bus_a.cmd_valid = 1; bus_a.cmd_write = 1; bus_a.cmd_addr = 8'h01; bus_a.cmd_data = 32'h0000000F;
    tick();
    bus_a.cmd_valid = 0;
    pulses = 0; seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(bus_a.verify_err);
      seen = seen | bus_a.rsp_valid;
      tick();
    end
    check("ver_err_pulses", pulses, 1);
    check("ver_err_count", bus_a.verify_err_count, 16'd1);
    check("ver_no_rsp", seen, 0);
    corrupt = 1'b0;
    bus_a.cmd_valid = 1; bus_a.cmd_write = 1; bus_a.cmd_addr = 8'h00; bus_a.cmd_data = 32'h0BADCAFE;
    tick();
    bus_a.cmd_valid = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(bus_a.verify_err);
      tick();
    end
    check("ver_clean_pulses", pulses, 0);
    check("ver_clean_count", bus_a.verify_err_count, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
